// File: rtl/adc_align_pkg.sv
// Shared types and helpers for the ADC DDR sync-align path.
// Holds the alignment FSM states and the channel/lane bit-packing rule.
package adc_align_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } align_state_t;

    // LSB of channel `chan`, lane `lane` in a bus packed as [(c*NPAR+l)*W +: W].
    function automatic int lane_lsb(input int chan, input int lane,
                                    input int npar, input int width);
        return (chan * npar + lane) * width;
    endfunction

endpackage

// File: rtl/adc_lane_align.sv
// Per-channel barrel realign: two capture stages, then a registered
// lane rotate so that output lane 0 carries the sample at lane `phase`.
module adc_lane_align #(
    parameter int NBITS = 12,
    parameter int NPAR  = 2,
    parameter int PHW   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NPAR*NBITS-1:0]   din,
    input  logic [PHW-1:0]          phase,
    output logic [NPAR*NBITS-1:0]   dout
);

    localparam int SELW = $clog2(2 * NPAR);

    logic [NPAR*NBITS-1:0] din_p1;
    logic [NPAR*NBITS-1:0] din_p2;
    logic [NPAR*NBITS-1:0] aligned;
    logic [NBITS-1:0]      win [2*NPAR];

    // stage 1/2: capture, then hold one word back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_p1 <= '0;
            din_p2 <= '0;
        end else begin
            din_p1 <= din;
            din_p2 <= din_p1;
        end
    end

    // Older word occupies window lanes 0..NPAR-1, newer word the rest.
    for (genvar l = 0; l < NPAR; l++) begin : g_win
        assign win[l]        = din_p2[l*NBITS +: NBITS];
        assign win[NPAR + l] = din_p1[l*NBITS +: NBITS];
    end

    for (genvar j = 0; j < NPAR; j++) begin : g_sel
        logic [SELW-1:0] sel;
        assign sel = SELW'(phase) + SELW'(j);
        assign aligned[j*NBITS +: NBITS] = win[sel];
    end

    // stage 3: registered output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= aligned;
        end
    end

endmodule

// File: rtl/adc_ddr_sync_align.sv
// Multi-channel DDR ADC capture: locks to the sync pulse (lane and period),
// realigns every channel to the sync sample and tracks sticky overrange.
module adc_ddr_sync_align
    import adc_align_pkg::*;
#(
    parameter int  NBITS      = 12,
    parameter int  NCHAN      = 2,
    parameter int  NPAR       = 2,
    parameter int  CNTW       = 16,
    parameter int  LOCK_COUNT = 4,
    localparam int PHW        = (NPAR > 1) ? $clog2(NPAR) : 1
) (
    input  logic                          adc_clk,
    input  logic                          adc_rst_n,
    input  logic [NCHAN*NPAR*NBITS-1:0]   din,
    input  logic [NCHAN*NPAR-1:0]         ovr_in,
    input  logic [NPAR-1:0]               sync_in,
    input  logic                          ovr_clr,
    input  logic                          relock,
    output logic [NCHAN*NPAR*NBITS-1:0]   dout,
    output logic                          dout_valid,
    output logic                          sync_out,
    output logic [NCHAN-1:0]              ovr_sticky,
    output logic                          locked,
    output logic [PHW-1:0]                phase,
    output logic [CNTW-1:0]               sync_period,
    output logic                          sync_err
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    align_state_t         state, state_nxt;
    logic [PHW-1:0]       phase_nxt;
    logic [CNTW-1:0]      period_nxt;
    logic [MW-1:0]        match, match_nxt;
    logic                 err_nxt;

    logic [NPAR-1:0]       sync_p1;
    logic [NCHAN*NPAR-1:0] ovr_p1;
    logic                  ovr_clr_p1;
    logic                  sync_evt_p2;
    logic                  sync_evt;
    logic [PHW-1:0]        sync_lane;
    logic [CNTW-1:0]       cnt;
    logic [CNTW:0]         period_plus1;
    logic                  lane_ok, count_ok, cnt_sat, missed;
    logic [NCHAN-1:0]      ovr_any;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        adc_lane_align #(
            .NBITS (NBITS),
            .NPAR  (NPAR),
            .PHW   (PHW)
        ) u_align (
            .clk   (adc_clk),
            .rst_n (adc_rst_n),
            .din   (din[lane_lsb(c, 0, NPAR, NBITS) +: NPAR*NBITS]),
            .phase (phase),
            .dout  (dout[lane_lsb(c, 0, NPAR, NBITS) +: NPAR*NBITS])
        );
        assign ovr_any[c] = |ovr_p1[lane_lsb(c, 0, NPAR, 1) +: NPAR];
    end

    // stage 1: registered sync/overrange; ovr_clr is delayed to meet its set
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            sync_p1    <= '0;
            ovr_p1     <= '0;
            ovr_clr_p1 <= 1'b0;
        end else begin
            sync_p1    <= sync_in;
            ovr_p1     <= ovr_in;
            ovr_clr_p1 <= ovr_clr;
        end
    end

    always_comb begin
        sync_evt  = |sync_p1;
        sync_lane = '0;
        for (int l = NPAR - 1; l >= 0; l--) begin
            if (sync_p1[l]) sync_lane = PHW'(l);
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            cnt <= '0;
        end else if (sync_evt) begin
            cnt <= CNTW'(1);
        end else if (!cnt_sat) begin
            cnt <= cnt + CNTW'(1);
        end
    end

    assign period_plus1 = {1'b0, sync_period} + {{CNTW{1'b0}}, 1'b1};
    assign lane_ok      = (sync_lane == phase);
    assign count_ok     = (cnt == sync_period);
    assign cnt_sat      = &cnt;
    assign missed       = ({1'b0, cnt} == period_plus1);

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state       <= SEARCH;
            phase       <= '0;
            sync_period <= '0;
            match       <= '0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            sync_period <= period_nxt;
            match       <= match_nxt;
            sync_err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        period_nxt = sync_period;
        match_nxt  = match;
        err_nxt    = sync_err;
        if (relock) begin
            // A sync event in the same cycle is deliberately discarded.
            state_nxt = SEARCH;
            match_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (sync_evt) begin
                        phase_nxt = sync_lane;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (sync_evt) begin
                        if (lane_ok) begin
                            period_nxt = cnt;
                            match_nxt  = MW'(1);
                            state_nxt  = CONFIRM;
                        end else begin
                            state_nxt = SEARCH;
                        end
                    end else if (cnt_sat) begin
                        state_nxt = SEARCH;
                    end
                end
                CONFIRM: begin
                    if (sync_evt) begin
                        if (lane_ok && count_ok) begin
                            match_nxt = match + MW'(1);
                            if (match == MW'(LOCK_COUNT - 1)) state_nxt = LOCKED;
                        end else begin
                            state_nxt = SEARCH;
                            err_nxt   = 1'b1;
                        end
                    end else if (cnt_sat) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (sync_evt ? (!lane_ok || !count_ok) : missed) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // stage 2/3: status aligned with the realigned output word
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            sync_evt_p2 <= 1'b0;
            sync_out    <= 1'b0;
            locked      <= 1'b0;
            ovr_sticky  <= '0;
        end else begin
            sync_evt_p2 <= sync_evt;
            sync_out    <= sync_evt_p2 && (state == LOCKED);
            locked      <= (state == LOCKED);
            ovr_sticky  <= (ovr_sticky & ~{NCHAN{ovr_clr_p1}}) | ovr_any;
        end
    end

    assign dout_valid = locked;

endmodule

// File: doc/adc_ddr_sync_align.md
Name: adc_ddr_sync_align

Overview:
- Parametrised successor to the single-ADC DDR capture path. Sits on the ADC clock domain directly after the per-pin IDDR de-interleave stage.
- Accepts NPAR samples per clock for each of NCHAN channels and locks to the ADC sync pulse (lane and period).
- Re-aligns every channel so that output lane 0 carries the sync-coincident sample.
- Provides sticky per-channel overrange flags and lock/error status to user logic.

Parameters:
NBITS, 12, sample width
NCHAN, 2, number of ADC channels
NPAR, 2, samples per clock per channel (2 = DDR); lane 0 is the earliest sample
CNTW, 16, sync period counter width
LOCK_COUNT, 4, consecutive matching periods required to lock
Localparam PHW = max(1, clog2(NPAR)).

Ports:
adc_clk  in  1  ADC line clock; the single clock of the block
adc_rst_n  in  1  reset, asynchronous, active-low
din  in  NCHAN*NPAR*NBITS  channel c, lane l at bits [(c*NPAR+l)*NBITS +: NBITS]
ovr_in  in  NCHAN*NPAR  overrange, same channel/lane ordering as din
sync_in  in  NPAR  ADC syncout, one bit per lane
ovr_clr  in  1  clear all sticky overrange flags
relock  in  1  force re-acquisition and clear sync_err
dout  out  NCHAN*NPAR*NBITS  aligned samples, same ordering as din
dout_valid  out  1  high while locked
sync_out  out  1  one-cycle pulse on the dout word whose lane 0 is the sync sample
ovr_sticky  out  NCHAN  per-channel sticky overrange
locked  out  1  state == LOCKED
phase  out  PHW  captured sync lane
sync_period  out  CNTW  measured period in adc_clk cycles
sync_err  out  1  sticky loss or mismatch indicator

Behaviour:
- Reset: all registers and outputs are 0; the FSM starts in SEARCH.
- Pipeline:
  - r1 <= din; r2 <= r1.
  - dout lane j = r2 lane (k+j) if k+j < NPAR, otherwise r1 lane (k+j-NPAR), where k = phase. Applied identically to every channel.
  - Fixed latency: word N presented at cycle t appears on dout at t+3, independent of phase.
- Sync detect on the registered sync (stage 1): sync event = any bit set; lane = lowest set index.
- Period counter: resets to 1 on each sync event, otherwise increments and saturates at all-ones.
- FSM:
  - SEARCH: on a sync event, capture phase → MEASURE.
  - MEASURE: on a sync event with the same lane, sync_period <= count, match = 1 → CONFIRM. A different lane or counter saturation → SEARCH.
  - CONFIRM: on a sync event with the same lane and count == sync_period, match++. When match reaches LOCK_COUNT → LOCKED. Any mismatch or saturation → SEARCH and set sync_err.
  - LOCKED: a sync event with the wrong lane or count != sync_period → SEARCH and set sync_err. If count reaches sync_period+1 with no sync event (missed sync) → SEARCH and set sync_err.
  - relock: → SEARCH from any state and clears sync_err. relock takes priority over a same-cycle sync event, which is ignored.
- Output timing:
  - dout_valid and locked are registered from the state and delayed to align with dout.
  - sync_out is the stage-1 sync event delayed to the dout stage, gated by locked.
- Overrange:
  - ovr_sticky[c] sets when any lane of channel c has the registered ovr_in set.
  - ovr_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- phase changes only in SEARCH; dout_valid is low whenever phase may change.

Decomposition:
- Package adc_align_pkg: FSM state enum (SEARCH, MEASURE, CONFIRM, LOCKED) and a lane-index extraction function for the channel/lane packing.
- One sub-module, adc_lane_align: per-channel NPAR-lane barrel realign (r1/r2 → dout), instantiated NCHAN times.
- The FSM, counter and sticky flags stay in the top level.

Test Plan:
1. Reset: assert adc_rst_n = 0 mid-stream → all outputs 0 while low and on release; FSM in SEARCH.
2. NPAR=2, NCHAN=2, ramp data, sync on lane 1 every 8 cycles:
   - locked rises after the 5th sync event; phase = 1; sync_period = 8.
   - sync_out coincides with dout lane 0 equal to the ramp value at sync.
   - dout lane 1 equals that value + 1.
3. Sync on lane 0, period 5 → phase = 0; dout equals din delayed 3 cycles exactly; no lane swap.
4. After lock, omit one sync pulse:
   - locked and dout_valid fall at the expected cycle; sync_err = 1.
   - Re-lock occurs after LOCK_COUNT+1 further syncs while sync_err stays 1.
   - relock pulse clears sync_err.
5. Pulse ovr_in for channel 1 lane 0 → ovr_sticky = 2'b10 after 2 cycles. Assert ovr_clr together with a new ovr_in on channel 1 → flag stays set. ovr_clr alone → 0.
6. relock asserted in CONFIRM on the same cycle as a valid sync event → state goes to SEARCH, the sync is ignored, and lock needs a full re-acquisition.
